// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and default frame width for piso_tx and the downstream sipo.
package piso_pkg;
    localparam int DATA_W_DEF = 8;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;
endpackage

// File: rtl/piso_hold.sv
// piso_hold: one-entry hold register with valid flag, used by piso_tx when PISO_TX_HOLD_EN is defined.
//   clk, rst  : clock, synchronous active-high reset (clears valid and data)
//   wr_en     : load wr_data and set valid
//   rd_en     : clear valid (data consumed)
//   valid     : entry occupied
//   data      : held byte
module piso_hold
    import piso_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic              valid,
    output logic [DATA_W-1:0] data
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // wr_en and rd_en are never asserted together: writes happen in SHIFT, reads in LATCH
    always_comb begin
        valid_d = rd_en ? 1'b0 : (wr_en ? 1'b1 : valid_q);
        data_d  = wr_en ? wr_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter feeding a sipo deserializer, LSB first, with mod framing.
//   clk, rst  : clock shared with sipo, synchronous active-high reset
//   in_data   : byte to transmit
//   in_valid  : in_data valid
//   in_ready  : transfer when in_valid && in_ready at a rising edge
//   se_out    : serial data, LSB first
//   mod       : 0 = downstream shifts, 1 = downstream captures/holds
//   busy      : high in SHIFT or LATCH
// Optional macro PISO_TX_HOLD_EN adds a one-entry hold register for back-to-back frames.
module piso_tx
    import piso_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              se_out,
    output logic              mod,
    output logic              busy
);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              accept;
    logic              last;

`ifdef PISO_TX_HOLD_EN
    logic              hold_valid;
    logic [DATA_W-1:0] hold_data;
    logic              hold_wr;
    logic              hold_rd;

    assign in_ready = !hold_valid;
    assign hold_wr  = accept && (state_q == SHIFT);
    assign hold_rd  = (state_q == LATCH) && hold_valid;

    piso_hold #(.DATA_W(DATA_W)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (hold_wr),
        .wr_data (in_data),
        .rd_en   (hold_rd),
        .valid   (hold_valid),
        .data    (hold_data)
    );
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign accept = in_valid && in_ready;
    assign last   = (cnt_q == CW'(DATA_W - 1));

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = shreg_q >> 1;
                cnt_d   = last ? '0 : cnt_q + 1'b1;
                state_d = last ? LATCH : SHIFT;
            end
            LATCH: begin
                state_d = IDLE;
`ifdef PISO_TX_HOLD_EN
                // a held byte wins; otherwise a byte accepted this cycle bypasses the hold
                if (hold_valid || accept) begin
                    shreg_d = hold_valid ? hold_data : in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // outputs decode registered state only, so there is no input-to-output path
    assign mod    = (state_q != SHIFT);
    assign se_out = (state_q == SHIFT) && shreg_q[0];
    assign busy   = (state_q != IDLE);
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed bench for piso_tx driving a behavioural sipo model.
module tb_piso_tx;
    import piso_pkg::*;

`ifdef PISO_TX_HOLD_EN
    localparam int PER = 9;
`else
    localparam int PER = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, se_out, mod, busy;

    always #5 clk = ~clk;

    piso_tx #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .se_out   (se_out),
        .mod      (mod),
        .busy     (busy)
    );

    logic [7:0] sr = 8'h00;
    logic [7:0] pa = 8'h00;
    int         cyc = 0;
    int         run = 0;
    int         st = 0;
    logic [7:0] cap_q[$];
    int         len_q[$];
    int         st_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            sr  <= 8'h00;
            pa  <= 8'h00;
            run <= 0;
        end else if (!mod) begin
            sr  <= {se_out, sr[7:1]};
            run <= run + 1;
            if (run == 0) st <= cyc;
        end else begin
            pa <= sr;
            if (run != 0) begin
                cap_q.push_back(sr);
                len_q.push_back(run);
                st_q.push_back(st);
            end
            run <= 0;
        end
    end

    int n_vec = 0;
    int n_bad = 0;
    int rd = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit rnd);
        bit acc = 1'b0;
        if (rnd) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 64 && !acc; t++) begin
            acc = in_ready;
            @(negedge clk);
        end
        chk("send_accept", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_caps(input int n);
        for (int t = 0; t < 8000 && cap_q.size() < rd + n; t++) @(negedge clk);
        chk("cap_count", cap_q.size(), rd + n);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 64) begin
            @(negedge clk);
            t++;
        end
        chk("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_cap(input string nm, input logic [7:0] b);
        if (rd < cap_q.size()) begin
            chk(nm, cap_q[rd], b);
            chk("mod_low_run", len_q[rd], 8);
        end else begin
            chk(nm, 32'hxx, b);
        end
        rd++;
    endtask

    typedef struct packed {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic [3:0] e;
        logic       cp;
        logic [7:0] pa;
    } vec_t;

    vec_t       tbl[11];
    logic [3:0] e;
    int         busy_n;
    logic [7:0] b2b[4];
    logic [7:0] rnd_b[200];

    initial begin
        // e = {mod, se_out, in_ready, busy} after the edge
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 4'b1010, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 8'hA5, 4'b0101, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 4'b0001, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 4'b0101, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 4'b0001, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 4'b0001, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 4'b0101, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 4'b0001, 1'b0, 8'h00};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 4'b0101, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 4'b1001, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 4'b1010, 1'b1, 8'hA5};
        b2b = '{8'h01, 8'h80, 8'hFF, 8'h00};

        repeat (2) @(negedge clk);
        busy_n = 0;
        foreach (tbl[i]) begin
            rst      = tbl[i].r;
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
            @(negedge clk);
`ifdef PISO_TX_HOLD_EN
            e = tbl[i].e | 4'b0010;
`else
            e = tbl[i].e;
`endif
            chk($sformatf("vec%0d", i), {28'd0, mod, se_out, in_ready, busy}, {28'd0, e});
            if (tbl[i].cp) chk("pa_out_a5", pa, tbl[i].pa);
            busy_n += busy ? 1 : 0;
        end
        chk("busy_cycles", busy_n, 9);
        wait_caps(1);
        chk_cap("cap_a5", 8'hA5);

        foreach (b2b[i]) send(b2b[i], 1'b0);
        wait_caps(4);
        for (int i = 0; i < 3; i++)
            if (rd + i + 1 < st_q.size()) chk("frame_period", st_q[rd+i+1] - st_q[rd+i], PER);
        foreach (b2b[i]) chk_cap("cap_b2b", b2b[i]);

        wait_idle();
        send(8'h5A, 1'b0);
        in_data  = 8'hC3;
        in_valid = 1'b1;
`ifdef PISO_TX_HOLD_EN
        chk("ready_shift0", {31'd0, in_ready}, 32'd1);
`else
        chk("ready_shift0", {31'd0, in_ready}, 32'd0);
`endif
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("ready_shift", {31'd0, in_ready}, 32'd0);
            in_data = 8'($urandom_range(0, 255));
        end
        in_valid = 1'b0;
`ifndef PISO_TX_HOLD_EN
        send(8'hC3, 1'b0);
`endif
        wait_caps(2);
        chk_cap("cap_5a", 8'h5A);
        chk_cap("cap_c3", 8'hC3);

        wait_idle();
        send(8'hE7, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outputs", {28'd0, mod, se_out, in_ready, busy}, 32'b1010);
        chk("abort_nocap", cap_q.size(), rd);
        send(8'h3C, 1'b0);
        wait_caps(1);
        chk_cap("cap_3c", 8'h3C);

        foreach (rnd_b[i]) begin
            rnd_b[i] = 8'($urandom_range(0, 255));
            send(rnd_b[i], 1'b1);
        end
        wait_caps(200);
        foreach (rnd_b[i]) chk_cap("cap_rand", rnd_b[i]);
        repeat (12) @(negedge clk);
        chk("no_extra_frames", cap_q.size(), rd);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
